// File: rtl/memory_access_pkg.sv
// Shared types for the RV64 memory stage: bus bundles, pipeline bundles, FSM state
// and helpers for access size, strobe mask and alignment.
package memory_access_pkg;

  typedef logic [63:0] word_t;
  typedef logic [63:0] addr_t;

  typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;

  typedef enum logic [3:0] {
    MEM_LB, MEM_LH, MEM_LW, MEM_LD,
    MEM_LBU, MEM_LHU, MEM_LWU,
    MEM_SB, MEM_SH, MEM_SW, MEM_SD
  } mem_op_t;

  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic [4:0] dst;
    mem_op_t    memop;
  } exec_ctl_t;

  typedef struct packed {
    addr_t       pc;
    logic [31:0] instruction;
    word_t       result;
    word_t       memdata;
    exec_ctl_t   ctl;
  } execute_data_t;

  typedef struct packed {
    logic       regwrite;
    logic [4:0] dst;
  } mem_ctl_t;

  typedef struct packed {
    addr_t       pc;
    logic [31:0] instruction;
    word_t       result;
    mem_ctl_t    ctl;
    logic        misalign;
  } memory_data_t;

  typedef struct packed {
    logic       valid;
    addr_t      addr;
    msize_t     size;
    logic [7:0] strobe;
    word_t      data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} mem_state_t;

  function automatic msize_t op_size(input mem_op_t op);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: op_size = MSIZE1;
      MEM_LH, MEM_LHU, MEM_SH: op_size = MSIZE2;
      MEM_LW, MEM_LWU, MEM_SW: op_size = MSIZE4;
      default:                 op_size = MSIZE8;
    endcase
  endfunction

  function automatic logic [7:0] size_mask(input msize_t size);
    case (size)
      MSIZE1:  size_mask = 8'h01;
      MSIZE2:  size_mask = 8'h03;
      MSIZE4:  size_mask = 8'h0f;
      default: size_mask = 8'hff;
    endcase
  endfunction

  function automatic logic is_misaligned(input msize_t size, input logic [2:0] offset);
    case (size)
      MSIZE2:  is_misaligned = offset[0];
      MSIZE4:  is_misaligned = |offset[1:0];
      MSIZE8:  is_misaligned = |offset;
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/memory_access_readdata.sv
// Load data extraction: shift bus word down to the byte offset, then sign/zero extend.
// Latency: combinational.
// Backpressure: none.
module memory_access_readdata
  import memory_access_pkg::*;
(
  input  word_t      rdata,
  input  logic [2:0] offset,
  input  mem_op_t    op,
  output word_t      load_data
);

  word_t shifted;

  always_comb begin
    shifted   = rdata >> {offset, 3'b000};
    load_data = shifted;
    case (op)
      MEM_LB:  load_data = {{56{shifted[7]}}, shifted[7:0]};
      MEM_LBU: load_data = {56'h0, shifted[7:0]};
      MEM_LH:  load_data = {{48{shifted[15]}}, shifted[15:0]};
      MEM_LHU: load_data = {48'h0, shifted[15:0]};
      MEM_LW:  load_data = {{32{shifted[31]}}, shifted[31:0]};
      MEM_LWU: load_data = {32'h0, shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// RV64 memory stage: registers execute bundle, runs dbus req/resp for loads/stores.
// Latency: 1 cycle for non-memory ops, 1 cycle + bus cycles for memory ops.
// Backpressure: stall held from aligned memory-op acceptance until the cycle data_ok arrives.
module memory_access
  import memory_access_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  execute_data_t dataE,
  input  logic          valid_in,
  output dbus_req_t     dreq,
  input  dbus_resp_t    dresp,
  output memory_data_t  dataM,
  output logic          valid_out,
  output logic          stall
);

  mem_state_t  state;
  logic        op_load;
  logic        op_regwrite;
  logic [4:0]  op_dst;
  mem_op_t     op_memop;
  addr_t       op_addr;
  addr_t       op_pc;
  logic [31:0] op_instr;

  word_t        load_data;
  memory_data_t comp_data;
  msize_t       in_size;
  logic         in_mem;
  logic         in_bad;
  logic         in_accept;
  logic         done;

  memory_access_readdata u_readdata (
    .rdata     (dresp.data),
    .offset    (op_addr[2:0]),
    .op        (op_memop),
    .load_data (load_data)
  );

  assign in_mem    = valid_in && (dataE.ctl.memread || dataE.ctl.memwrite);
  assign in_size   = op_size(dataE.ctl.memop);
  assign in_bad    = in_mem && is_misaligned(in_size, dataE.result[2:0]);
  assign in_accept = (state == ST_IDLE) && in_mem && !in_bad;
  // data_ok only counts once the address phase has been accepted
  assign done      = ((state == ST_REQ) && dresp.addr_ok && dresp.data_ok) ||
                     ((state == ST_WAIT) && dresp.data_ok);
  assign stall     = reset && (in_accept || ((state != ST_IDLE) && !done));

  always_comb begin
    comp_data              = '0;
    comp_data.pc           = op_pc;
    comp_data.instruction  = op_instr;
    comp_data.result       = op_load ? load_data : op_addr;
    comp_data.ctl.regwrite = op_regwrite;
    comp_data.ctl.dst      = op_dst;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      dreq        <= '0;
      dataM       <= '0;
      valid_out   <= 1'b0;
      op_load     <= 1'b0;
      op_regwrite <= 1'b0;
      op_dst      <= '0;
      op_memop    <= MEM_LB;
      op_addr     <= '0;
      op_pc       <= '0;
      op_instr    <= '0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_accept) begin
            op_load     <= dataE.ctl.memread;
            op_regwrite <= dataE.ctl.regwrite;
            op_dst      <= dataE.ctl.dst;
            op_memop    <= dataE.ctl.memop;
            op_addr     <= dataE.result;
            op_pc       <= dataE.pc;
            op_instr    <= dataE.instruction;
            dreq.valid  <= 1'b1;
            dreq.addr   <= dataE.result;
            dreq.size   <= in_size;
            dreq.strobe <= dataE.ctl.memwrite ?
                           (size_mask(in_size) << dataE.result[2:0]) : 8'h00;
            dreq.data   <= dataE.memdata << {dataE.result[2:0], 3'b000};
            state       <= ST_REQ;
          end else if (valid_in) begin
            // pass-through ops and misaligned accesses retire without touching the bus
            dataM.pc           <= dataE.pc;
            dataM.instruction  <= dataE.instruction;
            dataM.result       <= dataE.result;
            dataM.ctl.regwrite <= dataE.ctl.regwrite && !in_bad;
            dataM.ctl.dst      <= dataE.ctl.dst;
            dataM.misalign     <= in_bad;
            valid_out          <= 1'b1;
          end
        end
        ST_REQ: begin
          if (dresp.addr_ok) begin
            dreq.valid <= 1'b0;
            if (dresp.data_ok) begin
              dataM     <= comp_data;
              valid_out <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (dresp.data_ok) begin
            dataM     <= comp_data;
            valid_out <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/memory_access.md
# memory_access

Pipeline memory stage for the RV64 core. It registers the `execute_data_t` bundle produced by the execute stage and, for loads and stores, runs a request/response transaction on the data bus. It formats store strobes and data, and extends load data, then emits a `memory_data_t` bundle to writeback. While a bus transaction is outstanding it holds the upstream pipeline stalled.

## Interface
Parameters:
- none; all widths come from `common` (`word_t` = 64 bits, `addr_t` = 64 bits).

Ports:
- `clk`  in  1  core clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low reset, sampled on the `clk` rising edge.
- `dataE`  in  `execute_data_t`  execute-stage bundle; uses `result` as the address, plus `memdata`, `pc`, `instruction` and `ctl`.
- `valid_in`  in  1  `dataE` is a real instruction this cycle.
- `dreq`  out  `dbus_req_t`  data bus request: `valid`, `addr`, `size` (`msize_t`), `strobe[7:0]`, `data`.
- `dresp`  in  `dbus_resp_t`  data bus response: `addr_ok`, `data_ok`, `data`.
- `dataM`  out  `memory_data_t`  writeback bundle: `pc`, `instruction`, `result`, `ctl.regwrite`, `ctl.dst`, `misalign`.
- `valid_out`  out  1  `dataM` is valid this cycle.
- `stall`  out  1  upstream stages must hold; `dataE` is not consumed.

## Operation
- FSM states are IDLE, REQ and WAIT.
- **IDLE, memory op**
  - Condition: `valid_in` and (`ctl.memread` or `ctl.memwrite`), and the address is aligned.
  - Action: latch `dataE` into the operand register, drive `dreq.valid`=1, go to REQ.
- **IDLE, non-memory op**
  - Condition: `valid_in` and neither `ctl.memread` nor `ctl.memwrite`.
  - Action: `dataM.result` ← `dataE.result`, `valid_out`=1 next cycle, stay IDLE.
- **REQ**
  - Hold `dreq.valid`=1 and keep all `dreq` fields stable until `addr_ok`.
  - On `addr_ok` without `data_ok`, go to WAIT.
  - On `addr_ok` and `data_ok` in the same cycle, complete and go to IDLE.
  - `data_ok` without `addr_ok` is a protocol violation and is ignored.
- **WAIT**
  - `dreq.valid`=0.
  - On `data_ok`, complete and go to IDLE.
- **Completion**
  - Loads: `dataM.result` ← extended load data.
  - Stores: `dataM.result` ← the address.
  - In both cases `valid_out`=1 on the following cycle.
- **Sizes**
  - `LB`/`LBU`/`SB` = 1 byte, `LH`/`LHU`/`SH` = 2, `LW`/`LWU`/`SW` = 4, `LD`/`SD` = 8.
- **Store formatting**
  - `strobe` = (size mask) << `addr[2:0]`.
  - `data` = `memdata` << (8·`addr[2:0]`).
  - Loads drive `strobe`=0.
- **Load formatting**
  - Shift `dresp.data` right by 8·`addr[2:0]`, truncate to the access size.
  - Signed ops sign-extend to 64 bits; `U` ops zero-extend.
- **Misalignment**
  - Condition: `addr` not a multiple of the access size.
  - No bus request is issued and no stall is raised.
  - `dataM.misalign`=1, `ctl.regwrite` forced to 0, `valid_out`=1 next cycle.
- **`stall`**
  - Asserted in REQ and in WAIT.
  - Asserted combinationally in IDLE when an aligned memory op is presented.
  - Deasserted in the cycle `data_ok` is seen, so upstream advances in that same cycle.

## Timing
- **Reset** (`reset`=0 at an edge):
  - State → IDLE.
  - `dreq.valid`=0, `valid_out`=0, `stall`=0, and all `dataM` fields = 0.
- **Latency**
  - Non-memory op: 1 cycle.
  - Memory op: 1 cycle + bus cycles. With `addr_ok` and `data_ok` both in the first REQ cycle, `valid_out` comes 2 cycles after acceptance.
- **Pulse width**: `valid_out` is high for exactly one cycle per instruction. It is 0 whenever no instruction completed in the previous cycle.
- **Reset mid-transaction**
  - State returns to IDLE and `dreq.valid` drops at the next edge.
  - A `data_ok` arriving later is ignored in IDLE.
  - No `valid_out` is produced for the aborted instruction.
- **Stability**: `dreq` fields never change while `dreq.valid`=1 and `addr_ok`=0.
- **Back-to-back**: a new memory op can be accepted in the cycle after completion. There is no stall bubble beyond the FSM return to IDLE.

## Structure
- **`common` package**:
  - `msize_t` (MSIZE1/2/4/8).
  - `dbus_req_t` and `dbus_resp_t`.
- **`pipes` package**:
  - `memory_data_t`.
  - The FSM state enum `mem_state_t`.
- **Sub-module `readdata`** (combinational):
  - Inputs: `dresp.data`, `addr[2:0]`, `op`.
  - Output: the extended load word.
- Store formatting and the FSM stay in `memory_access`.

## Test plan
- **ADD pass-through**: `valid_in`=1, result=`0x1234`, no mem op → next cycle `valid_out`=1, `dataM.result`=`0x1234`, `stall` never asserted.
- **LB, same-cycle response**: addr=`0x8003`, `dresp.data`=`0x00000000_80000000`, `addr_ok`=`data_ok`=1 first cycle → `dreq.size`=MSIZE1, `strobe`=0, `dataM.result`=`0xFFFFFFFF_FFFFFF80` two cycles after acceptance; `LBU` gives `0x80`.
- **SH with delays**: addr=`0x8006`, `memdata`=`0xBEEF`, `addr_ok` after 3 cycles, `data_ok` 2 cycles later → `strobe`=`0xC0`, `data[63:48]`=`0xBEEF`, `dreq` stable until `addr_ok`, `stall` high throughout, exactly one `valid_out`.
- **Misaligned LW**: addr=`0x8002` → no `dreq.valid`, `misalign`=1, `regwrite`=0, `stall` low.
- **Reset mid-transaction**: reset in WAIT, then a late `data_ok` → `dreq.valid`=0 and `valid_out`=0 after reset, state IDLE, late response ignored.
- **Back-to-back**: LD then SD presented consecutively → both complete in order, with two `valid_out` pulses.
